// File: rtl/shape_raster_engine_if.sv
// -----------------------------------------------------------------------------
// shape_raster_if
// Bundles the draw-command handshake and the framebuffer write port of the
// shape rasteriser.
//   master : command issuer / framebuffer owner (drives cmd_*, fb_ready)
//   slave  : the rasteriser (drives cmd_ready, fb_we, fb_addr, fb_data)
// Widths are derived from the screen size exactly as inside the engine, so
// both must be given the same H_RES / V_RES / COLOR_W.
// -----------------------------------------------------------------------------
interface shape_raster_if #(
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int COLOR_W = 2
);
   localparam int X_W    = $clog2(H_RES) + 1;
   localparam int Y_W    = $clog2(V_RES) + 1;
   localparam int ADDR_W = $clog2(H_RES * V_RES);

   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [1:0]                cmd_op;
   logic                      cmd_erase;
   logic [COLOR_W-1:0]        cmd_color;
   logic signed [X_W-1:0]     cmd_x;
   logic signed [Y_W-1:0]     cmd_y;
   logic [X_W-2:0]            cmd_w;
   logic [Y_W-2:0]            cmd_hr;

   logic                      fb_we;
   logic [ADDR_W-1:0]         fb_addr;
   logic [COLOR_W-1:0]        fb_data;
   logic                      fb_ready;

   modport master (
      output cmd_valid, cmd_op, cmd_erase, cmd_color, cmd_x, cmd_y, cmd_w, cmd_hr,
      output fb_ready,
      input  cmd_ready, fb_we, fb_addr, fb_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_erase, cmd_color, cmd_x, cmd_y, cmd_w, cmd_hr,
      input  fb_ready,
      output cmd_ready, fb_we, fb_addr, fb_data
   );
endinterface

// File: rtl/shape_raster_engine.sv
// -----------------------------------------------------------------------------
// shape_raster_engine
// Rasterises rectangles, filled circles and full-screen clears into a
// framebuffer, one candidate pixel per cycle, clipped to the screen.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : cmd_valid/cmd_ready command handshake with op, erase, colour,
//                 signed x/y, width, height-or-radius; fb_we/fb_addr/fb_data
//                 write port with fb_ready backpressure
//   busy        : command in progress (SETUP, SCAN, DONE)
//   done        : one-cycle completion pulse
//   pix_count   : framebuffer writes completed for the last/current command
// -----------------------------------------------------------------------------
module shape_raster_engine #(
   parameter int  H_RES   = 640,
   parameter int  V_RES   = 480,
   parameter int  COLOR_W = 2,
   localparam int X_W     = $clog2(H_RES) + 1,
   localparam int Y_W     = $clog2(V_RES) + 1,
   localparam int ADDR_W  = $clog2(H_RES * V_RES)
) (
   input  logic            clk,
   input  logic            rst_n,
   shape_raster_if.slave   bus,
   output logic            busy,
   output logic            done,
   output logic [ADDR_W:0] pix_count
);
   // Common signed width: holds x+w-1, cx+r and px-cx without overflow.
   localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 3;
   // Squared-distance width: a sum of two squares of CW-bit values.
   localparam int SW = 2 * CW + 1;
   localparam logic signed [CW-1:0] ZERO = '0;
   localparam logic signed [CW-1:0] ONE  = CW'(1);
   localparam logic signed [CW-1:0] XMAX = CW'(H_RES - 1);
   localparam logic signed [CW-1:0] YMAX = CW'(V_RES - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;
   state_t state, state_nxt;

   logic [1:0]            op_r;
   logic                  erase_r;
   logic [COLOR_W-1:0]    color_r;
   logic signed [X_W-1:0] x_r;
   logic signed [Y_W-1:0] y_r;
   logic [X_W-2:0]        w_r;
   logic [Y_W-2:0]        hr_r;
   logic [X_W-2:0]        bx0_r, bx1_r, px_r;
   logic [Y_W-2:0]        by0_r, by1_r, py_r;

   function automatic logic signed [CW-1:0] clamp(input logic signed [CW-1:0] v,
                                                  input logic signed [CW-1:0] hi);
      if (v < ZERO) return ZERO;
      if (v > hi)   return hi;
      return v;
   endfunction

   logic accept;
   assign accept = bus.cmd_valid && (state == IDLE);

   logic signed [CW-1:0] xs, ys, ws, rs, pxs, pys;
   assign xs  = {{(CW-X_W){x_r[X_W-1]}}, x_r};
   assign ys  = {{(CW-Y_W){y_r[Y_W-1]}}, y_r};
   assign ws  = {{(CW-X_W+1){1'b0}}, w_r};
   assign rs  = {{(CW-Y_W+1){1'b0}}, hr_r};
   assign pxs = {{(CW-X_W+1){1'b0}}, px_r};
   assign pys = {{(CW-Y_W+1){1'b0}}, py_r};

   // Unclipped bounding box; clear and reserved use the whole screen, the
   // reserved op is then forced empty.
   logic signed [CW-1:0] lo_x, hi_x, lo_y, hi_y;
   logic                 box_empty;
   always_comb begin
      lo_x = ZERO;
      hi_x = XMAX;
      lo_y = ZERO;
      hi_y = YMAX;
      case (op_r)
         2'b00: begin
            lo_x = xs;      hi_x = xs + ws - ONE;
            lo_y = ys;      hi_y = ys + rs - ONE;
         end
         2'b01: begin
            lo_x = xs - rs; hi_x = xs + rs;
            lo_y = ys - rs; hi_y = ys + rs;
         end
         default: ;
      endcase
      // Emptiness must be judged before clamping, which would otherwise pull
      // an off-screen box onto the screen edge.
      box_empty = (op_r == 2'b11) || (hi_x < lo_x) || (hi_y < lo_y) ||
                  (lo_x > XMAX) || (hi_x < ZERO) || (lo_y > YMAX) || (hi_y < ZERO);
   end

   // Circle membership for the current scan pixel.
   logic signed [CW-1:0] dx, dy;
   logic signed [SW-1:0] dxe, dye, re, dist2, r2;
   logic                 in_shape;
   assign dx       = pxs - xs;
   assign dy       = pys - ys;
   assign dxe      = {{(SW-CW){dx[CW-1]}}, dx};
   assign dye      = {{(SW-CW){dy[CW-1]}}, dy};
   assign re       = {{(SW-CW){rs[CW-1]}}, rs};
   assign dist2    = dxe * dxe + dye * dye;
   assign r2       = re * re;
   assign in_shape = (op_r != 2'b01) || (dist2 <= r2);

   logic              advance, last_x, last_y;
   logic [ADDR_W-1:0] lin_addr;
   assign advance  = !in_shape || bus.fb_ready;
   assign last_x   = (px_r == bx1_r);
   assign last_y   = (py_r == by1_r);
   assign lin_addr = ADDR_W'(py_r) * ADDR_W'(H_RES) + ADDR_W'(px_r);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.cmd_valid) state_nxt = SETUP;
         SETUP:   state_nxt = box_empty ? DONE : SCAN;
         SCAN:    if (advance && last_x && last_y) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Write port is forced quiet outside SCAN, so the datapath registers need
   // no reset.
   always_comb begin
      bus.cmd_ready = (state == IDLE);
      busy          = (state != IDLE);
      done          = (state == DONE);
      bus.fb_we     = (state == SCAN) && in_shape;
      bus.fb_addr   = (state == SCAN) ? lin_addr : '0;
      bus.fb_data   = ((state == SCAN) && !erase_r) ? color_r : '0;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_r    <= bus.cmd_op;
         erase_r <= bus.cmd_erase;
         color_r <= bus.cmd_color;
         x_r     <= bus.cmd_x;
         y_r     <= bus.cmd_y;
         w_r     <= bus.cmd_w;
         hr_r    <= bus.cmd_hr;
      end
      if (state == SETUP) begin
         bx0_r <= (X_W-1)'(clamp(lo_x, XMAX));
         bx1_r <= (X_W-1)'(clamp(hi_x, XMAX));
         by0_r <= (Y_W-1)'(clamp(lo_y, YMAX));
         by1_r <= (Y_W-1)'(clamp(hi_y, YMAX));
         px_r  <= (X_W-1)'(clamp(lo_x, XMAX));
         py_r  <= (Y_W-1)'(clamp(lo_y, YMAX));
      end else if ((state == SCAN) && advance) begin
         if (last_x) begin
            px_r <= bx0_r;
            py_r <= py_r + 1'b1;
         end else begin
            px_r <= px_r + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        pix_count <= '0;
      else if (accept)                   pix_count <= '0;
      else if (bus.fb_we && bus.fb_ready) pix_count <= pix_count + (ADDR_W+1)'(1);
   end
endmodule
